icache_refill_responder: RTL and testbench
==========================================

Name: icache_refill_responder

Overview:
Memory-side responder for I-cache line refills. It accepts one block-refill request at a time and waits a programmable access latency. It then returns the 512-bit block as 16 32-bit beats, critical word first, under valid/ready flow control. It backs a word-addressed instruction memory, preloadable through a loader port, and serves as the far end of the I-cache miss interface in simulation and FPGA builds.

Parameters:
DATA_W, `data_size (32), beat width in bits
ADDR_W, `pc_size (32), request address width
BLOCK_BITS, `icache_blocksize (512), refill block size in bits
BEATS, BLOCK_BITS/DATA_W (16), beats per refill; power of two
LATENCY, 4, idle cycles between request accept and first beat; 0 allowed
MEM_WORDS, 4096, backing array depth in DATA_W words

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  refill request valid
req_ready  out  1  responder can accept a request
req_addr  in  ADDR_W  byte address of the missing instruction
rsp_valid  out  1  beat valid
rsp_ready  in  1  cache accepts beat
rsp_data  out  DATA_W  beat data
rsp_beat  out  log2(BEATS)  word offset of this beat within the block
rsp_last  out  1  final beat of the refill
rsp_err  out  1  block lies outside the backing array
ld_we  in  1  loader write enable
ld_addr  in  log2(MEM_WORDS)  loader word address
ld_data  in  DATA_W  loader write data

Behaviour:
- Reset: state IDLE, beat counter 0, latency counter 0. Outputs: rsp_valid=0, rsp_last=0, rsp_err=0, rsp_data=0, rsp_beat=0, req_ready=0 while rst is high. Array contents are not cleared.
- Reset asserted mid-burst or mid-wait: abort immediately (asynchronous). rsp_valid drops in the same cycle; no residual beats after release.
- FSM states: IDLE, WAIT, BURST.
- IDLE: req_ready=1.
  - On req_valid&&req_ready, latch block = req_addr[ADDR_W-1:6] and start = req_addr[5:2]. req_addr[1:0] are ignored.
  - Go to WAIT with counter = LATENCY-1, or go straight to BURST if LATENCY==0.
- WAIT: req_ready=0, rsp_valid=0. Decrement each cycle; at 0 go to BURST.
- Timing: handshake in cycle 0 gives first rsp_valid in cycle LATENCY+1.
- BURST: rsp_valid=1.
  - Word offset = (start + n) mod BEATS, where n = number of beats already accepted.
  - rsp_beat = that offset; rsp_data = mem[block*BEATS + offset].
  - n advances only on rsp_valid&&rsp_ready.
  - While rsp_ready=0, rsp_data, rsp_beat and rsp_last stay stable.
  - rsp_last=1 exactly when n==BEATS-1.
  - When the last beat is accepted, return to IDLE. req_ready rises the next cycle; there is no same-cycle re-accept.
- Out of range: if block*BEATS >= MEM_WORDS, latch err. All BEATS beats are still issued, with rsp_err=1 and rsp_data=0. Timing is unchanged.
- Loader: ld_we writes mem[ld_addr] at the clock edge, in IDLE only. Writes in WAIT or BURST are ignored. Reads are combinational from the array.
- Illegal requests: req_valid outside IDLE is not accepted. The requester must hold req_valid and req_addr until req_ready.

Decomposition:
- Shared constants package gets:
  - derived `icache_beats (BLOCK_BITS/`data_size) and `icache_offset_bits (log2 of block bytes);
  - typedef enum refill_state {R_IDLE, R_WAIT, R_BURST}, so the I-cache miss FSM and this block share naming.
- One sub-module, refill_mem_array, is natural: a synchronous-write, combinational-read word array with the loader port and an IDLE-gated write enable. The FSM, counters and handshake stay in icache_refill_responder.

Test Plan:
Preload mem[i]=0xA000_0000+i; LATENCY=4; rsp_ready=1 throughout.
1. Aligned refill, req_addr=0x0000_0040 handshaked in cycle 0 -> beats in cycles 5..20. rsp_data 0xA000_0010..0xA000_001F, rsp_beat 0..15, rsp_last only in cycle 20, req_ready=1 in cycle 21.
2. Critical-word-first, req_addr=0x0000_0078 -> rsp_beat sequence 14,15,0,1,...,13. Data 0xA000_001E, 0xA000_001F, 0xA000_0010, ..., 0xA000_001D; rsp_last on beat 13.
3. Backpressure: test 1 with rsp_ready=0 in cycles 7-9 -> beat 2 (0xA000_0012) held stable for cycles 7-10. Last beat in cycle 23; exactly 16 beats accepted.
4. Out of range, req_addr=0x0000_4000 (MEM_WORDS=4096) -> 16 beats with rsp_err=1 and rsp_data=0, same timing as test 1. The next in-range request has rsp_err=0.
5. Reset mid-burst: assert rst in cycle 8 of test 1 -> rsp_valid=0 in the same cycle, req_ready=0 while rst is high. After release, req_ready=1 and a new request for 0x0000_0080 returns 0xA000_0020 first.
6. Loader gating: ld_we with ld_addr=0x11, ld_data=0xDEAD_BEEF during a test-1 burst is ignored (0xA000_0011 returned). The same write in IDLE followed by the test-1 request returns 0xDEAD_BEEF on beat 1.

Source files
------------

// File: rtl/icache_refill_responder_pkg.sv
// Shared constants and state naming for the I-cache refill path.
// The I-cache miss FSM and the memory-side responder both use these names.
package icache_refill_responder_pkg;

  localparam int DATA_SIZE          = 32;
  localparam int PC_SIZE            = 32;
  localparam int ICACHE_BLOCKSIZE   = 512;
  localparam int ICACHE_BEATS       = ICACHE_BLOCKSIZE / DATA_SIZE;
  localparam int ICACHE_OFFSET_BITS = $clog2(ICACHE_BLOCKSIZE / 8);

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_BURST
  } refill_state_t;

endpackage

// File: rtl/refill_mem_array.sv
// Word-addressed instruction store behind the refill responder.
// Synchronous loader write (gated by the caller), combinational read.
module refill_mem_array
  import icache_refill_responder_pkg::*;
#(
  parameter  int DATA_W    = DATA_SIZE,
  parameter  int MEM_WORDS = 4096,
  localparam int MEM_AW    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              i_ld_we,
  input  logic              i_ld_gate,
  input  logic [MEM_AW-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic [MEM_AW-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  // NOTE: the array has no reset; clearing thousands of words would force
  // flops instead of RAM, and preloaded contents must survive a reset.
  always_ff @(posedge clk) begin
    if (i_ld_we && i_ld_gate) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side I-cache refill responder: one request at a time, programmable
// access latency, then a critical-word-first burst of BEATS data beats.
module icache_refill_responder
  import icache_refill_responder_pkg::*;
#(
  parameter  int DATA_W     = DATA_SIZE,
  parameter  int ADDR_W     = PC_SIZE,
  parameter  int BLOCK_BITS = ICACHE_BLOCKSIZE,
  parameter  int BEATS      = BLOCK_BITS / DATA_W,
  parameter  int LATENCY    = 4,
  parameter  int MEM_WORDS  = 4096,
  localparam int BEAT_W     = $clog2(BEATS),
  localparam int MEM_AW     = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [BEAT_W-1:0] rsp_beat,
  output logic              rsp_last,
  output logic              rsp_err,
  input  logic              ld_we,
  input  logic [MEM_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int WORD_BITS = $clog2(DATA_W / 8);
  localparam int OFF_BITS  = WORD_BITS + BEAT_W;
  localparam int BLK_W     = ADDR_W - OFF_BITS;
  localparam int IDX_W     = MEM_AW - BEAT_W;
  localparam int LAT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BLK_W-1:0]  BLK_LIMIT = BLK_W'(MEM_WORDS / BEATS);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;
  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(BEATS - 1);

  refill_state_t     r_state;
  refill_state_t     w_state_nxt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [LAT_W-1:0]  w_lat_nxt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic [IDX_W-1:0]  r_block;
  logic [BEAT_W-1:0] r_start;
  logic              r_err;

  logic              w_idle;
  logic              w_burst;
  logic              w_accept;
  logic              w_last;
  logic [BLK_W-1:0]  w_req_block;
  logic [BEAT_W-1:0] w_req_start;
  logic              w_req_err;
  logic [BEAT_W-1:0] w_offset;
  logic [MEM_AW-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused_addr;

  // Byte-within-word bits never select anything: refills are word granular.
  assign w_unused_addr = ^req_addr[WORD_BITS-1:0];

  assign w_req_block = req_addr[ADDR_W-1:OFF_BITS];
  assign w_req_start = req_addr[OFF_BITS-1:WORD_BITS];
  assign w_req_err   = (w_req_block >= BLK_LIMIT);

  assign w_idle   = (r_state == R_IDLE) && !rst;
  assign w_burst  = (r_state == R_BURST);
  assign w_accept = req_valid && w_idle;
  assign w_last   = (r_beat_cnt == BEAT_MAX);

  // Offset wraps within the block, giving critical-word-first order.
  assign w_offset  = r_start + r_beat_cnt;
  assign w_rd_addr = {r_block, w_offset};

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    w_state_nxt = r_state;
    w_lat_nxt   = r_lat_cnt;
    w_beat_nxt  = r_beat_cnt;
    unique case (r_state)
      R_IDLE: begin
        if (w_accept) begin
          w_beat_nxt = '0;
          if (LATENCY == 0) begin
            w_state_nxt = R_BURST;
          end else begin
            w_state_nxt = R_WAIT;
            w_lat_nxt   = LAT_LOAD;
          end
        end
      end
      R_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_state_nxt = R_BURST;
        end else begin
          w_lat_nxt = r_lat_cnt - 1'b1;
        end
      end
      R_BURST: begin
        if (rsp_ready) begin
          if (w_last) begin
            w_state_nxt = R_IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= R_IDLE;
      r_lat_cnt  <= '0;
      r_beat_cnt <= '0;
      r_block    <= '0;
      r_start    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat_cnt  <= w_lat_nxt;
      r_beat_cnt <= w_beat_nxt;
      if (w_accept) begin
        r_block <= w_req_block[IDX_W-1:0];
        r_start <= w_req_start;
        r_err   <= w_req_err;
      end
    end
  end

  // Loader writes land only while idle, so a burst never sees its block change.
  refill_mem_array #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk       (clk),
    .i_ld_we   (ld_we),
    .i_ld_gate (w_idle),
    .i_ld_addr (ld_addr),
    .i_ld_data (ld_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign req_ready = w_idle;
  assign rsp_valid = w_burst;
  assign rsp_beat  = w_burst ? w_offset : '0;
  assign rsp_last  = w_burst && w_last;
  assign rsp_err   = w_burst && r_err;
  assign rsp_data  = (w_burst && !r_err) ? w_rd_data : '0;

endmodule

// File: tb/tb_icache_refill_responder.sv
// Bench for icache_refill_responder: directed refill scenarios plus random
// traffic, checked every cycle against a queue-based model of the refill.
module tb_icache_refill_responder;

  localparam int LAT   = 4;
  localparam int BEATS = 16;
  localparam int MEMW  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_beat;
  logic        rsp_last;
  logic        rsp_err;
  logic        ld_we = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  icache_refill_responder #(
    .LATENCY   (LAT),
    .MEM_WORDS (MEMW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_beat  (rsp_beat),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] data;
    int          beat;
    bit          last;
    bit          err;
  } beat_t;

  // Model: word array, queue of beats still owed, cycle the first beat is due.
  logic [31:0] m_mem [MEMW];
  beat_t       m_q[$];
  beat_t       acc_q[$];
  int          m_first  = 0;
  int          hs_cyc   = 0;
  int          hs_count = 0;
  bit          m_idle;
  bit          m_exp_valid;
  bit          rand_mode = 1'b0;

  task automatic build_refill(input logic [31:0] addr);
    longint blk;
    int     start;
    bit     err;
    beat_t  b;
    blk   = longint'(addr >> 6);
    start = int'((addr >> 2) & 32'hF);
    err   = (blk * BEATS) >= MEMW;
    for (int n = 0; n < BEATS; n++) begin
      b.cyc  = 0;
      b.beat = (start + n) % BEATS;
      b.err  = err;
      b.last = (n == BEATS - 1);
      b.data = err ? 32'h0 : m_mem[int'(blk * BEATS) + b.beat];
      m_q.push_back(b);
    end
    m_first = cyc + LAT + 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_last", rsp_last, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_beat", rsp_beat, 0);
      m_q.delete();
    end else begin
      m_idle      = (m_q.size() == 0);
      m_exp_valid = !m_idle && (cyc >= m_first);
      check("req_ready", req_ready, m_idle);
      check("rsp_valid", rsp_valid, m_exp_valid);
      if (m_exp_valid && rsp_valid) begin
        check("rsp_data", rsp_data, m_q[0].data);
        check("rsp_beat", rsp_beat, m_q[0].beat);
        check("rsp_last", rsp_last, m_q[0].last);
        check("rsp_err", rsp_err, m_q[0].err);
        if (rsp_ready) begin
          beat_t a;
          a.cyc  = cyc;
          a.data = rsp_data;
          a.beat = int'(rsp_beat);
          a.last = rsp_last;
          a.err  = rsp_err;
          acc_q.push_back(a);
          void'(m_q.pop_front());
        end
      end
      if (m_idle && ld_we) m_mem[ld_addr] = ld_data;
      if (m_idle && req_valid) begin
        build_refill(req_addr);
        hs_cyc = cyc;
        hs_count++;
      end
    end
  end

  task automatic step();
    if (rand_mode) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      ld_we     = ($urandom_range(0, 7) == 0);
      ld_addr   = 12'($urandom);
      ld_data   = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] addr);
    int h0;
    h0 = hs_count;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int k = 0; k < 200; k++) begin
      step();
      if (hs_count != h0) break;
    end
    req_valid = 1'b0;
    check("req_handshake", hs_count - h0, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2000; k++) begin
      if (m_q.size() == 0) break;
      step();
    end
    check("idle_reached", m_q.size(), 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    check("lit_rst_req_ready", req_ready, 0);
    check("lit_rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < MEMW; i++) begin
      ld_we   = 1'b1;
      ld_addr = 12'(i);
      ld_data = 32'hA000_0000 + 32'(i);
      step();
    end
    ld_we = 1'b0;
    step();

    // Aligned refill
    acc_q.delete();
    do_req(32'h0000_0040);
    wait_idle();
    check("t1_count", acc_q.size(), 16);
    check("t1_first_cyc", acc_q[0].cyc - hs_cyc, 5);
    check("t1_first_data", acc_q[0].data, 32'hA000_0010);
    check("t1_first_beat", acc_q[0].beat, 0);
    check("t1_last_cyc", acc_q[15].cyc - hs_cyc, 20);
    check("t1_last_data", acc_q[15].data, 32'hA000_001F);
    check("t1_last_flag", acc_q[15].last, 1);
    check("t1_ready_cyc", cyc - hs_cyc, 21);
    check("t1_ready_back", req_ready, 1);
    step();

    // Critical word first
    acc_q.delete();
    do_req(32'h0000_0078);
    wait_idle();
    check("t2_first_beat", acc_q[0].beat, 14);
    check("t2_first_data", acc_q[0].data, 32'hA000_001E);
    check("t2_wrap_data", acc_q[2].data, 32'hA000_0010);
    check("t2_last_beat", acc_q[15].beat, 13);
    check("t2_last_data", acc_q[15].data, 32'hA000_001D);
    check("t2_last_flag", acc_q[15].last, 1);
    step();

    // Backpressure in cycles 7..9
    acc_q.delete();
    do_req(32'h0000_0040);
    repeat (6) step();
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    wait_idle();
    check("t3_count", acc_q.size(), 16);
    check("t3_beat2_cyc", acc_q[2].cyc - hs_cyc, 10);
    check("t3_beat2_data", acc_q[2].data, 32'hA000_0012);
    check("t3_last_cyc", acc_q[15].cyc - hs_cyc, 23);
    step();

    // Out of range block, then an in-range one
    acc_q.delete();
    do_req(32'h0000_4000);
    wait_idle();
    check("t4_count", acc_q.size(), 16);
    check("t4_err", acc_q[0].err, 1);
    check("t4_data", acc_q[0].data, 0);
    check("t4_first_cyc", acc_q[0].cyc - hs_cyc, 5);
    check("t4_last_cyc", acc_q[15].cyc - hs_cyc, 20);
    step();
    acc_q.delete();
    do_req(32'h0000_0040);
    wait_idle();
    check("t4_next_err", acc_q[0].err, 0);
    check("t4_next_data", acc_q[0].data, 32'hA000_0010);
    step();

    // Reset in cycle 8 of a burst
    acc_q.delete();
    do_req(32'h0000_0040);
    repeat (7) step();
    rst = 1'b1;
    #1;
    check("t5_valid_in_rst", rsp_valid, 0);
    check("t5_ready_in_rst", req_ready, 0);
    step();
    step();
    rst = 1'b0;
    check("t5_beats_before_rst", acc_q.size(), 3);
    step();
    check("t5_ready_after", req_ready, 1);
    check("t5_no_residual", rsp_valid, 0);
    acc_q.delete();
    do_req(32'h0000_0080);
    wait_idle();
    check("t5_new_first", acc_q[0].data, 32'hA000_0020);
    step();

    // Loader gating
    acc_q.delete();
    do_req(32'h0000_0040);
    repeat (4) step();
    ld_we   = 1'b1;
    ld_addr = 12'h011;
    ld_data = 32'hDEAD_BEEF;
    step();
    ld_we = 1'b0;
    wait_idle();
    check("t6_busy_write_ignored", acc_q[1].data, 32'hA000_0011);
    step();
    ld_we = 1'b1;
    step();
    ld_we = 1'b0;
    acc_q.delete();
    do_req(32'h0000_0040);
    wait_idle();
    check("t6_idle_write_beat", acc_q[1].beat, 1);
    check("t6_idle_write_data", acc_q[1].data, 32'hDEAD_BEEF);
    step();

    // Random traffic
    rand_mode = 1'b1;
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) step();
      do_req($urandom_range(0, 32'h7FFF));
      wait_idle();
    end
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    ld_we     = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
